// File: rtl/gps_epoch_dump_master_if.sv
// gps_epoch_dump_master_if
// Groups the Wishbone classic read bus and the tagged output stream of the
// epoch dump master into one bundle.
//   wbm_adr_o / wbm_we_o / wbm_cyc_o / wbm_stb_o : initiator -> correlator
//   wbm_dat_i / wbm_ack_i                        : correlator -> initiator
//   out_data / out_ch / out_valid                : dump master -> consumer
//   out_ready                                    : consumer -> dump master
// The master modport is the dump master's view; the slave modport is the
// view of whatever sits on the far side (correlator plus capture path).
interface gps_epoch_dump_master_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;
  logic [31:0] out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output wbm_adr_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i,
    output out_data, out_ch, out_valid,
    input  out_ready
  );

  modport slave (
    input  wbm_adr_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i,
    input  out_data, out_ch, out_valid,
    output out_ready
  );
endinterface

// File: rtl/gps_epoch_dump_master.sv
// gps_epoch_dump_master
// Wishbone classic-cycle initiator that, whenever a tracking channel raises
// its code-epoch line, reads that channel's register window from the
// correlator and queues the words (tagged with the channel index) in a FIFO
// that drains through a valid/ready stream.
// Ports:
//   mclk          single clock for bus and logic
//   mclr          asynchronous active-low reset
//   epoch_in      per-channel epoch level, each rising edge requests a dump
//   ch_enable     per-channel eligibility mask for epoch edges
//   clr_err       one-cycle pulse clearing the sticky flags
//   bus           Wishbone read bus plus output stream (master modport)
//   fifo_level    current FIFO occupancy
//   busy          high whenever the sequencer is not idle
//   missed_epoch  sticky: an epoch arrived for a channel already pending
//   timeout_err   sticky: at least one read was abandoned without ack
module gps_epoch_dump_master #(
  parameter int NUM_CH     = 8,
  parameter int NUM_REGS   = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                        mclk,
  input  logic                        mclr,
  input  logic [NUM_CH-1:0]           epoch_in,
  input  logic [NUM_CH-1:0]           ch_enable,
  input  logic                        clr_err,
  gps_epoch_dump_master_if.master     bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        missed_epoch,
  output logic                        timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int CH_W  = 3;
  localparam logic [31:0] TIMEOUT_WORD = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_REQ, S_WAIT, S_GAP} state_t;

  state_t                state;
  state_t                next_state;

  logic [NUM_CH-1:0]     epoch_cur;
  logic [NUM_CH-1:0]     epoch_prev;
  logic [NUM_CH-1:0]     rise;
  logic [NUM_CH-1:0]     pending;
  logic [NUM_CH-1:0]     grant_vec;
  logic                  missed_ev;
  logic                  timeout_ev;

  logic [CH_W-1:0]       ch_q;
  logic [CH_W-1:0]       ch_d;
  logic [CH_W-1:0]       last_served;
  logic [CH_W-1:0]       last_d;
  logic [CH_W-1:0]       rr_ch;
  logic [CH_W-1:0]       cand;
  logic                  rr_found;
  logic [REG_W-1:0]      reg_q;
  logic [REG_W-1:0]      reg_d;
  logic [TMR_W-1:0]      timer;
  logic                  cyc_q;
  logic [31:0]           adr_q;
  logic                  space_ok;

  logic                  push;
  logic [CH_W+31:0]      push_word;
  logic                  pop;
  logic [CH_W+31:0]      mem [FIFO_DEPTH];
  logic [CH_W+31:0]      head;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      count;
  logic                  out_valid_int;

  // Edge detect works on the registered copy so a rise is seen for exactly
  // one cycle; disabled channels are masked here and never become pending.
  assign rise = epoch_cur & ~epoch_prev & ch_enable;

  // A fresh rise on a channel that is still waiting is a lost epoch. The
  // channel being granted this cycle is excluded: its bit is about to clear,
  // so the new rise simply re-arms it.
  assign missed_ev = |(rise & pending & ~grant_vec);

  // Space for a whole dump is checked before granting, which guarantees the
  // pushes of that dump never find the FIFO full.
  assign space_ok = (FIFO_DEPTH - int'(count)) >= NUM_REGS;

  assign out_valid_int = (count != '0);
  assign head          = mem[rd_ptr];
  assign pop           = out_valid_int & bus.out_ready;

  // Round-robin search: the first pending channel after the last one served,
  // wrapping modulo NUM_CH.
  always_comb begin
    rr_ch    = '0;
    rr_found = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = CH_W'((int'(last_served) + i) % NUM_CH);
      if (!rr_found && pending[cand]) begin
        rr_found = 1'b1;
        rr_ch    = cand;
      end
    end
  end

  // Sequencer next-state logic: grant in ARB, one read per REQ/WAIT/GAP
  // triple, and the FIFO push decision made in WAIT.
  always_comb begin
    next_state = state;
    grant_vec  = '0;
    ch_d       = ch_q;
    reg_d      = reg_q;
    last_d     = last_served;
    push       = 1'b0;
    push_word  = '0;
    timeout_ev = 1'b0;
    case (state)
      S_IDLE: begin
        if (|pending) next_state = S_ARB;
      end
      S_ARB: begin
        if (rr_found && space_ok) begin
          grant_vec  = NUM_CH'(1'b1) << rr_ch;
          ch_d       = rr_ch;
          reg_d      = '0;
          next_state = S_REQ;
        end else if (!(|pending)) begin
          next_state = S_IDLE;
        end
      end
      S_REQ: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.wbm_ack_i && cyc_q) begin
          push       = 1'b1;
          push_word  = {ch_q, bus.wbm_dat_i};
          next_state = S_GAP;
        end else if (timer == TMR_W'(TIMEOUT - 1)) begin
          push       = 1'b1;
          push_word  = {ch_q, TIMEOUT_WORD};
          timeout_ev = 1'b1;
          next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (reg_q != REG_W'(NUM_REGS - 1)) begin
          reg_d      = reg_q + 1'b1;
          next_state = S_REQ;
        end else begin
          last_d     = ch_q;
          next_state = (|pending) ? S_ARB : S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Sequencer registers. Bus outputs are registered from next_state so they
  // are glitch-free and fall together with the asynchronous reset.
  always_ff @(posedge mclk or negedge mclr) begin
    if (!mclr) begin
      state       <= S_IDLE;
      ch_q        <= '0;
      reg_q       <= '0;
      last_served <= '0;
      timer       <= '0;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
    end else begin
      state       <= next_state;
      ch_q        <= ch_d;
      reg_q       <= reg_d;
      last_served <= last_d;
      if (state == S_WAIT && next_state == S_WAIT) timer <= timer + 1'b1;
      else                                         timer <= '0;
      cyc_q <= (next_state == S_REQ) || (next_state == S_WAIT);
      if (next_state == S_REQ && state != S_REQ)
        adr_q <= {24'h00_000A + 24'(ch_d), 8'({reg_d, 2'b00})};
    end
  end

  // Epoch capture, pending set/clear, and the sticky error flags. A flag
  // event coinciding with clr_err leaves the flag set.
  always_ff @(posedge mclk or negedge mclr) begin
    if (!mclr) begin
      epoch_cur    <= '0;
      epoch_prev   <= '0;
      pending      <= '0;
      missed_epoch <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      epoch_cur    <= epoch_in;
      epoch_prev   <= epoch_cur;
      pending      <= (pending & ~grant_vec) | rise;
      missed_epoch <= (missed_epoch & ~clr_err) | missed_ev;
      timeout_err  <= (timeout_err & ~clr_err) | timeout_ev;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level
  // unchanged.
  always_ff @(posedge mclk or negedge mclr) begin
    if (!mclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LVL_W'(push) - LVL_W'(pop);
    end
  end

  // FIFO storage needs no reset: the stream outputs are masked while empty.
  always_ff @(posedge mclk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_we_o  = 1'b0;
  assign bus.wbm_cyc_o = cyc_q;
  assign bus.wbm_stb_o = cyc_q;
  assign bus.out_valid = out_valid_int;
  assign bus.out_data  = out_valid_int ? head[31:0] : '0;
  assign bus.out_ch    = out_valid_int ? head[CH_W+31:32] : '0;
  assign fifo_level    = count;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_gps_epoch_dump_master.sv
// tb_gps_epoch_dump_master
// Scoreboard bench: stimulus pushes the expected output words, a consumer
// process pops and compares whenever a transfer happens, and a bus responder
// plays the correlator.
module tb_gps_epoch_dump_master;
  typedef struct {
    logic [2:0]  ch;
    logic [31:0] data;
  } exp_t;

  logic       mclk = 1'b0;
  logic       mclr = 1'b0;
  logic [7:0] epoch_in = '0;
  logic [7:0] ch_enable = 8'hFF;
  logic       clr_err = 1'b0;
  logic [4:0] fifo_level;
  logic       busy;
  logic       missed_epoch;
  logic       timeout_err;

  gps_epoch_dump_master_if bus ();

  gps_epoch_dump_master dut (
    .mclk(mclk), .mclr(mclr), .epoch_in(epoch_in), .ch_enable(ch_enable),
    .clr_err(clr_err), .bus(bus), .fifo_level(fifo_level), .busy(busy),
    .missed_epoch(missed_epoch), .timeout_err(timeout_err)
  );

  always #5 mclk = ~mclk;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] adr_log[$];
  int          run_log[$];
  int          last_served_m = 0;
  logic [7:0]  mute_mask = '0;
  logic [31:0] key = 32'h1234_5678;
  bit          use_table = 1'b0;
  logic [31:0] table_words[4];
  int          ready_mode = 2;
  int          pop_budget = 0;
  int          fixed_delay = 0;
  bit          rand_delay = 1'b0;
  int          max_level = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Correlator register contents as the bench defines them.
  function automatic logic [31:0] slave_word(input logic [31:0] adr);
    if (use_table) return table_words[adr[3:2]];
    return key ^ (adr * 32'h9E37_79B1);
  endfunction

  // Reference model: all channels in mask pending at once are served in
  // round-robin order after the last served channel, four words each.
  function automatic void expect_burst(input logic [7:0] mask);
    int base = last_served_m;
    for (int i = 1; i <= 8; i++) begin
      int c = (base + i) % 8;
      if (mask[c]) begin
        for (int r = 0; r < 4; r++) begin
          exp_t e;
          logic [31:0] adr;
          adr    = {24'h00_000A + 24'(c), 8'(r * 4)};
          e.ch   = 3'(c);
          e.data = mute_mask[c] ? 32'hDEAD_BEEF : slave_word(adr);
          exp_q.push_back(e);
        end
        last_served_m = c;
      end
    end
  endfunction

  task automatic applyStimulus(input logic [7:0] mask);
    @(negedge mclk);
    epoch_in = mask;
    expect_burst(mask & ch_enable);
    repeat (2) @(negedge mclk);
    epoch_in = '0;
  endtask

  task automatic checkOutput(input int limit);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < limit) begin
      @(negedge mclk);
      n++;
    end
    check("drain_in_time", 64'(n < limit), 64'd1);
  endtask

  // Correlator responder: acks after a delay counted from the WAIT cycle,
  // never acks muted channels, and logs addresses and strobe lengths.
  initial begin
    int          stb_cnt = 0;
    int          delay = 0;
    logic [31:0] cur_adr = '0;
    logic [7:0]  chb;
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;
    forever begin
      @(negedge mclk);
      if (!bus.wbm_stb_o) begin
        if (stb_cnt > 0) run_log.push_back(stb_cnt);
        stb_cnt = 0;
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = '0;
      end else begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          cur_adr = bus.wbm_adr_o;
          adr_log.push_back(cur_adr);
          delay = rand_delay ? int'($urandom_range(0, 4)) : fixed_delay;
          check("we_low", 64'(bus.wbm_we_o), 64'd0);
        end else if (bus.wbm_adr_o !== cur_adr || bus.wbm_cyc_o !== 1'b1) begin
          check("adr_cyc_stable", {bus.wbm_cyc_o, bus.wbm_adr_o}, {1'b1, cur_adr});
        end
        chb = cur_adr[15:8] - 8'h0A;
        if (!mute_mask[chb[2:0]] && stb_cnt >= 2 + delay) begin
          bus.wbm_ack_i = 1'b1;
          bus.wbm_dat_i = slave_word(cur_adr);
        end
      end
    end
  end

  // Consumer and scoreboard monitor: decides out_ready, and every transfer
  // that will happen at the next rising edge is compared with the queue head.
  initial begin
    bit          held = 1'b0;
    logic [34:0] held_word = '0;
    exp_t        e;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge mclk);
      case (ready_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        3:       bus.out_ready = (pop_budget > 0);
        default: bus.out_ready = 1'b1;
      endcase
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (mclr && held && bus.out_valid)
        check("head_stable", {29'd0, bus.out_ch, bus.out_data}, {29'd0, held_word});
      held = mclr && bus.out_valid && !bus.out_ready;
      held_word = {bus.out_ch, bus.out_data};
      if (mclr && bus.out_valid && bus.out_ready) begin
        if (ready_mode == 3) pop_budget--;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got ch=%0d data=0x%08h, expected none",
                   bus.out_ch, bus.out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_ch", 64'(bus.out_ch), 64'(e.ch));
          check("out_data", 64'(bus.out_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #800000;
    failures++;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 800000ns");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int first_k;
    int hold_stb;
    // Reset state.
    repeat (3) @(negedge mclk);
    check("rst_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_adr_o}, 64'd0);
    check("rst_stream", {bus.out_valid, bus.out_ch, bus.out_data}, 64'd0);
    check("rst_status", {fifo_level, busy, missed_epoch, timeout_err}, 64'd0);
    mclr = 1'b1;
    repeat (2) @(negedge mclk);

    // Single epoch on channel 2 with fixed data and zero-wait ack.
    $display("[TB] single epoch");
    use_table = 1'b1;
    table_words[0] = 32'h11; table_words[1] = 32'h22;
    table_words[2] = 32'h33; table_words[3] = 32'h44;
    ready_mode = 0;
    adr_log.delete();
    @(negedge mclk);
    epoch_in = 8'h04;
    expect_burst(8'h04);
    first_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge mclk);
      if (bus.wbm_stb_o && first_k == 0) first_k = k;
    end
    epoch_in = '0;
    check("stb_latency", 64'(first_k), 64'd4);
    n = 0;
    while (busy && n < 200) begin @(negedge mclk); n++; end
    check("dump1_done", 64'(n < 200), 64'd1);
    check("dump1_level", 64'(fifo_level), 64'd4);
    check("dump1_head_ch", {bus.out_valid, bus.out_ch}, {1'b1, 3'd2});
    check("adr0", 64'(adr_log[0]), 64'h0C00);
    check("adr1", 64'(adr_log[1]), 64'h0C04);
    check("adr2", 64'(adr_log[2]), 64'h0C08);
    check("adr3", 64'(adr_log[3]), 64'h0C0C);
    ready_mode = 2;
    checkOutput(300);
    use_table = 1'b0;

    // Round robin after channel 3 was served: 7, 0, 3.
    $display("[TB] round robin");
    applyStimulus(8'h08);
    checkOutput(300);
    adr_log.delete();
    applyStimulus(8'h89);
    checkOutput(600);
    check("rr_count", 64'(adr_log.size()), 64'd12);
    check("rr_first", 64'(adr_log[0][15:8]), 64'h11);
    check("rr_second", 64'(adr_log[4][15:8]), 64'h0A);
    check("rr_third", 64'(adr_log[8][15:8]), 64'h0D);

    // Channel 1 never acks.
    $display("[TB] timeout");
    mute_mask = 8'h02;
    adr_log.delete();
    run_log.delete();
    applyStimulus(8'h02);
    checkOutput(2000);
    check("to_reads_issued", 64'(adr_log.size()), 64'd4);
    check("to_stb_length", 64'(run_log.size() > 0 && run_log[0] >= 255 && run_log[0] <= 257), 64'd1);
    check("to_flag", 64'(timeout_err), 64'd1);
    mute_mask = '0;
    @(negedge mclk); clr_err = 1'b1;
    @(negedge mclk); clr_err = 1'b0;
    check("to_flag_cleared", 64'(timeout_err), 64'd0);

    // Backpressure: fill, drain three, then a new epoch must wait for space.
    $display("[TB] backpressure");
    ready_mode = 0;
    applyStimulus(8'h0F);
    n = 0;
    while ((busy || fifo_level != 5'd16) && n < 500) begin @(negedge mclk); n++; end
    check("bp_full", 64'(fifo_level), 64'd16);
    pop_budget = 3;
    ready_mode = 3;
    n = 0;
    while (fifo_level != 5'd13 && n < 50) begin @(negedge mclk); n++; end
    ready_mode = 0;
    check("bp_level13", 64'(fifo_level), 64'd13);
    applyStimulus(8'h40);
    hold_stb = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge mclk);
      if (bus.wbm_stb_o || bus.wbm_cyc_o) hold_stb++;
    end
    check("bp_no_bus", 64'(hold_stb), 64'd0);
    check("bp_busy", 64'(busy), 64'd1);
    check("bp_level_held", 64'(fifo_level), 64'd13);
    pop_budget = 1;
    ready_mode = 3;
    n = 0;
    while ((busy || fifo_level != 5'd16) && n < 200) begin @(negedge mclk); n++; end
    check("bp_granted", 64'(fifo_level), 64'd16);
    ready_mode = 2;
    checkOutput(300);
    check("bp_max_level", 64'(max_level <= 16), 64'd1);

    // Two rises on channel 5 while channel 0 is being dumped.
    $display("[TB] missed epoch");
    fixed_delay = 8;
    adr_log.delete();
    @(negedge mclk);
    epoch_in = 8'h01;
    expect_burst(8'h01);
    repeat (2) @(negedge mclk);
    epoch_in = '0;
    repeat (4) @(negedge mclk);
    epoch_in = 8'h20;
    expect_burst(8'h20);
    repeat (2) @(negedge mclk);
    epoch_in = '0;
    repeat (2) @(negedge mclk);
    check("missed_before", 64'(missed_epoch), 64'd0);
    epoch_in = 8'h20;
    repeat (2) @(negedge mclk);
    epoch_in = '0;
    checkOutput(600);
    check("missed_flag", 64'(missed_epoch), 64'd1);
    check("missed_one_dump", 64'(adr_log.size()), 64'd8);
    @(negedge mclk); clr_err = 1'b1;
    @(negedge mclk); clr_err = 1'b0;
    check("missed_cleared", 64'(missed_epoch), 64'd0);

    // Reset while a read is waiting for ack.
    $display("[TB] reset mid-wait");
    fixed_delay = 20;
    @(negedge mclk);
    epoch_in = 8'h10;
    n = 0;
    while (!bus.wbm_stb_o && n < 50) begin @(negedge mclk); n++; end
    check("rw_started", 64'(bus.wbm_stb_o), 64'd1);
    repeat (3) @(negedge mclk);
    epoch_in = '0;
    #2 mclr = 1'b0;
    #1;
    check("rw_bus_dropped", {bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
    check("rw_status", {fifo_level, busy, bus.out_valid}, 64'd0);
    exp_q.delete();
    last_served_m = 0;
    repeat (2) @(negedge mclk);
    mclr = 1'b1;
    fixed_delay = 1;
    repeat (2) @(negedge mclk);
    applyStimulus(8'h10);
    checkOutput(300);

    // Randomized bursts with random enables, ack delays and backpressure.
    $display("[TB] random bursts");
    rand_delay = 1'b1;
    ready_mode = 1;
    for (int it = 0; it < 25; it++) begin
      @(negedge mclk);
      key = $urandom;
      ch_enable = 8'($urandom);
      applyStimulus(8'($urandom_range(1, 255)));
      checkOutput(3000);
    end
    ch_enable = 8'hFF;
    check("rand_no_missed", 64'(missed_epoch), 64'd0);
    check("rand_no_timeout", 64'(timeout_err), 64'd0);
    check("rand_empty", {fifo_level, busy}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
